// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch control block: FSM states, preset pair
// selectors, per-pair tens limits and the terminal count.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_LAP   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] SEL_HUND = 2'd0;
  localparam logic [1:0] SEL_SEC  = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;

  localparam logic [3:0] TENS_MAX_HUND = 4'd9;
  localparam logic [3:0] TENS_MAX_SEC  = 4'd5;
  localparam logic [3:0] TENS_MAX_MIN  = 4'd5;

  localparam logic [23:0] MAX_COUNT = 24'h595999;

  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      SEL_HUND: oh = 3'b001;
      SEL_SEC:  oh = 3'b010;
      SEL_MIN:  oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bcd_pair_check.sv
// Combinational legality check for a two-digit BCD preset aimed at one
// counter pair; selector 3 never validates.
module bcd_pair_check
  import stopwatch_pkg::*;
(
  input  logic [1:0] preset_sel_i,
  input  logic [7:0] preset_val_i,
  output logic       valid_o
);

  logic [3:0] units;
  logic [3:0] tens;

  assign units = preset_val_i[3:0];
  assign tens  = preset_val_i[7:4];

  always_comb begin
    valid_o = 1'b0;
    case (preset_sel_i)
      SEL_HUND: valid_o = (units <= 4'd9) && (tens <= TENS_MAX_HUND);
      SEL_SEC:  valid_o = (units <= 4'd9) && (tens <= TENS_MAX_SEC);
      SEL_MIN:  valid_o = (units <= 4'd9) && (tens <= TENS_MAX_MIN);
      default:  valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Control FSM for the six-digit BCD stopwatch: gates the 10 ms tick into the
// counter chain, sequences start/stop, lap freeze, clear and preset loads.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_i,
  input  logic        start_stop_i,
  input  logic        lap_reset_i,
  input  logic        preset_load_i,
  input  logic [1:0]  preset_sel_i,
  input  logic [7:0]  preset_val_i,
  input  logic [23:0] cnt_digits_i,
  output logic        count_en_o,
  output logic        clr_o,
  output logic [2:0]  ld_en_o,
  output logic [7:0]  ld_val_o,
  output logic [23:0] disp_digits_o,
  output logic        frozen_o,
  output logic        running_o,
  output logic        wrap_o,
  output logic        err_o,
  output logic [2:0]  state_o
);

  state_e      state_q, state_d;
  logic [23:0] lap_q, lap_d;
  logic        clr_d, err_d, wrap_d, load_ok;
  logic [2:0]  ld_en_d;
  logic        preset_ok, running, at_max, lap_key;

  bcd_pair_check u_check (
    .preset_sel_i (preset_sel_i),
    .preset_val_i (preset_val_i),
    .valid_o      (preset_ok)
  );

  // Keys, clr_o, ld_en_o, wrap_o and err_o are all single-cycle strobes with no
  // back-pressure: a strobe is consumed in the cycle it is high, ld_val_o is
  // only meaningful while ld_en_o is non-zero.
  assign running    = (state_q == ST_RUN) || (state_q == ST_LAP);
  assign at_max     = running && tick_i && (cnt_digits_i == MAX_COUNT);
  assign lap_key    = lap_reset_i && !start_stop_i;
  assign count_en_o = tick_i && running && !(STOP_AT_MAX && at_max);

  assign load_ok = preset_load_i && preset_ok && !start_stop_i && !lap_reset_i &&
                   ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
  assign err_d   = preset_load_i && !load_ok;
  assign ld_en_d = load_ok ? sel_onehot(preset_sel_i) : 3'b000;

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    clr_d   = 1'b0;
    wrap_d  = 1'b0;
    if (STOP_AT_MAX && at_max) begin
      state_d = ST_DONE;
    end else begin
      wrap_d = at_max;
      case (state_q)
        ST_IDLE: begin
          if (start_stop_i)  state_d = ST_RUN;
          else if (load_ok)  state_d = ST_PAUSE;
        end
        ST_RUN: begin
          if (start_stop_i) begin
            state_d = ST_PAUSE;
          end else if (lap_key) begin
            state_d = ST_LAP;
            lap_d   = cnt_digits_i;
          end
        end
        ST_LAP: begin
          if (start_stop_i) state_d = ST_PAUSE;
          else if (lap_key) state_d = ST_RUN;
        end
        ST_PAUSE: begin
          if (start_stop_i) begin
            state_d = ST_RUN;
          end else if (lap_key) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
          end
        end
        ST_DONE: begin
          if (lap_key) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      lap_q     <= 24'h0;
      clr_o     <= 1'b0;
      err_o     <= 1'b0;
      wrap_o    <= 1'b0;
      ld_en_o   <= 3'b000;
      ld_val_o  <= 8'h00;
      frozen_o  <= 1'b0;
      running_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      lap_q     <= lap_d;
      clr_o     <= clr_d;
      err_o     <= err_d;
      wrap_o    <= wrap_d;
      ld_en_o   <= ld_en_d;
      if (load_ok) ld_val_o <= preset_val_i;
      frozen_o  <= (state_d == ST_LAP);
      running_o <= (state_d == ST_RUN) || (state_d == ST_LAP);
    end
  end

  assign state_o       = state_q;
  assign disp_digits_o = frozen_o ? lap_q : cnt_digits_i;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: both STOP_AT_MAX variants run side by side, fed by
// a centisecond-integer counter model, checked against a queued reference.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  typedef struct packed {
    logic        ss;
    logic        lr;
    logic        ld;
    logic [1:0]  sel;
    logic [7:0]  val;
    logic        tick;
  } stim_t;

  typedef struct packed {
    logic [2:0]  st;
    logic        frozen;
    logic [23:0] lap;
    logic        clr;
    logic        err;
    logic        wrap;
    logic [2:0]  ld_en;
    logic [7:0]  ld_val;
  } mdl_t;

  typedef struct packed {
    logic        cen;
    logic [2:0]  st;
    logic        frozen;
    logic        running;
    logic        clr;
    logic        err;
    logic        wrap;
    logic [2:0]  ld_en;
    logic [7:0]  ld_val;
    logic [23:0] disp;
  } obs_t;

  localparam int W = $bits(obs_t);

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        tick, start_stop, lap_reset, preset_load;
  logic [1:0]  preset_sel;
  logic [7:0]  preset_val;
  logic [23:0] cnt_digits;

  logic        cen_a, clr_a, frz_a, run_a, wrap_a, err_a;
  logic [2:0]  ld_en_a, st_a;
  logic [7:0]  ld_val_a;
  logic [23:0] disp_a;
  logic        cen_b, clr_b, frz_b, run_b, wrap_b, err_b;
  logic [2:0]  ld_en_b, st_b;
  logic [7:0]  ld_val_b;
  logic [23:0] disp_b;

  stopwatch_ctrl #(.STOP_AT_MAX(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .tick_i(tick), .start_stop_i(start_stop),
    .lap_reset_i(lap_reset), .preset_load_i(preset_load), .preset_sel_i(preset_sel),
    .preset_val_i(preset_val), .cnt_digits_i(cnt_digits), .count_en_o(cen_a),
    .clr_o(clr_a), .ld_en_o(ld_en_a), .ld_val_o(ld_val_a), .disp_digits_o(disp_a),
    .frozen_o(frz_a), .running_o(run_a), .wrap_o(wrap_a), .err_o(err_a), .state_o(st_a)
  );

  stopwatch_ctrl #(.STOP_AT_MAX(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .tick_i(tick), .start_stop_i(start_stop),
    .lap_reset_i(lap_reset), .preset_load_i(preset_load), .preset_sel_i(preset_sel),
    .preset_val_i(preset_val), .cnt_digits_i(cnt_digits), .count_en_o(cen_b),
    .clr_o(clr_b), .ld_en_o(ld_en_b), .ld_val_o(ld_val_b), .disp_digits_o(disp_b),
    .frozen_o(frz_b), .running_o(run_b), .wrap_o(wrap_b), .err_o(err_b), .state_o(st_b)
  );

  // scoreboard state
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  int n_total = 0;
  int n_pass  = 0;

  mdl_t ma, mb;
  int   chain;  // counter chain value in hundredths of a second

  // reference model
  function automatic logic [23:0] to_bcd(input int c);
    int h, s, m;
    h = c % 100;
    s = (c / 100) % 60;
    m = c / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  function automatic int load_pair(input int c, input logic [1:0] sel, input logic [7:0] val);
    int h, s, m, v;
    h = c % 100;
    s = (c / 100) % 60;
    m = c / 6000;
    v = int'(val[7:4]) * 10 + int'(val[3:0]);
    if (sel == 2'd0) h = v;
    else if (sel == 2'd1) s = v;
    else m = v;
    return m * 6000 + s * 100 + h;
  endfunction

  function automatic bit preset_legal(input logic [1:0] sel, input logic [7:0] val);
    int units, tens;
    units = int'(val) % 16;
    tens  = int'(val) / 16;
    if (sel == 2'd3) return 1'b0;
    return (units <= 9) && (tens <= ((sel == 2'd0) ? 9 : 5));
  endfunction

  function automatic bit is_running(input logic [2:0] st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

  function automatic void step(input mdl_t m, input bit stop, input stim_t s,
                               input logic [23:0] cnt, output logic cen, output mdl_t nm);
    bit run, max_hit, lr, accept;
    run     = is_running(m.st);
    max_hit = run && s.tick && (cnt == 24'h595999);
    cen     = run && s.tick && !(stop && max_hit);
    lr      = s.lr && !s.ss;
    accept  = s.ld && preset_legal(s.sel, s.val) && !s.ss && !s.lr &&
              ((m.st == ST_IDLE) || (m.st == ST_PAUSE));
    nm       = m;
    nm.clr   = 1'b0;
    nm.wrap  = 1'b0;
    nm.err   = s.ld && !accept;
    nm.ld_en = accept ? 3'(1 << s.sel) : 3'b000;
    if (accept) nm.ld_val = s.val;
    if (stop && max_hit) begin
      nm.st = ST_DONE;
    end else begin
      nm.wrap = max_hit;
      if (m.st == ST_IDLE) begin
        if (s.ss) nm.st = ST_RUN;
        else if (accept) nm.st = ST_PAUSE;
      end else if (m.st == ST_RUN) begin
        if (s.ss) nm.st = ST_PAUSE;
        else if (lr) begin nm.st = ST_LAP; nm.lap = cnt; end
      end else if (m.st == ST_LAP) begin
        if (s.ss) nm.st = ST_PAUSE;
        else if (lr) nm.st = ST_RUN;
      end else if (m.st == ST_PAUSE) begin
        if (s.ss) nm.st = ST_RUN;
        else if (lr) begin nm.st = ST_IDLE; nm.clr = 1'b1; end
      end else begin
        if (lr) begin nm.st = ST_IDLE; nm.clr = 1'b1; end
      end
    end
    nm.frozen = (nm.st == ST_LAP);
  endfunction

  function automatic obs_t expect_obs(input logic cen, input mdl_t m, input logic [23:0] cnt);
    obs_t o;
    o = {cen, m.st, m.frozen, is_running(m.st), m.clr, m.err, m.wrap, m.ld_en, m.ld_val,
         (m.frozen ? m.lap : cnt)};
    return o;
  endfunction

  function automatic stim_t mk(input bit ss, input bit lr, input bit ld,
                               input logic [1:0] sel, input logic [7:0] val, input bit tk);
    stim_t s;
    s = {ss, lr, ld, sel, val, tk};
    return s;
  endfunction

  // driver
  task automatic cycle(input bit rst, input stim_t s);
    logic        ca, cb;
    mdl_t        na, nb;
    logic [23:0] cnt;
    @(posedge clk);
    #1;
    if (rst) begin
      chain = 0;
      ma    = '0;
      mb    = '0;
    end
    cnt         = to_bcd(chain);
    reset_n     = !rst;
    start_stop  = s.ss;
    lap_reset   = s.lr;
    preset_load = s.ld;
    preset_sel  = s.sel;
    preset_val  = s.val;
    tick        = s.tick;
    cnt_digits  = cnt;
    if (rst) begin
      ca = 1'b0; cb = 1'b0; na = ma; nb = mb;
    end else begin
      step(ma, 1'b1, s, cnt, ca, na);
      step(mb, 1'b0, s, cnt, cb, nb);
    end
    exp_a.push_back(expect_obs(ca, ma, cnt));
    exp_b.push_back(expect_obs(cb, mb, cnt));
    if (!rst) begin
      if (ma.clr) chain = 0;
      else if (ma.ld_en != 3'b000) chain = load_pair(chain, preset_sel, ma.ld_val);
      else if (ca) chain = (chain + 1) % 360000;
    end
    ma = na;
    mb = nb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 0));
  endtask

  // monitor
  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".count_en"}, 24'(a.cen), 24'(e.cen));
    chk({tag, ".state"}, 24'(a.st), 24'(e.st));
    chk({tag, ".frozen"}, 24'(a.frozen), 24'(e.frozen));
    chk({tag, ".running"}, 24'(a.running), 24'(e.running));
    chk({tag, ".clr"}, 24'(a.clr), 24'(e.clr));
    chk({tag, ".err"}, 24'(a.err), 24'(e.err));
    chk({tag, ".wrap"}, 24'(a.wrap), 24'(e.wrap));
    chk({tag, ".ld_en"}, 24'(a.ld_en), 24'(e.ld_en));
    if (e.ld_en != 3'b000) chk({tag, ".ld_val"}, 24'(a.ld_val), 24'(e.ld_val));
    chk({tag, ".disp"}, a.disp, e.disp);
  endtask

  always @(negedge clk) begin : monitor
    obs_t ea, eb, aa, ab;
    if (exp_a.size() > 0 && exp_b.size() > 0) begin
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      aa = {cen_a, st_a, frz_a, run_a, clr_a, err_a, wrap_a, ld_en_a, ld_val_a, disp_a};
      ab = {cen_b, st_b, frz_b, run_b, clr_b, err_b, wrap_b, ld_en_b, ld_val_b, disp_b};
      cmp("stop1", aa, ea);
      cmp("wrap0", ab, eb);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // stimulus
  initial begin
    stim_t s;
    tick = 0; start_stop = 0; lap_reset = 0; preset_load = 0;
    preset_sel = 0; preset_val = 0; cnt_digits = 0;
    ma = '0; mb = '0; chain = 0;

    cycle(1'b1, mk(0, 0, 0, 2'd0, 8'h00, 0));
    cycle(1'b1, mk(0, 0, 0, 2'd0, 8'h00, 0));

    // start, five ticks, stop
    cycle(1'b0, mk(1, 0, 0, 2'd0, 8'h00, 0));
    for (int i = 0; i < 10; i++) cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, i[0]));
    cycle(1'b0, mk(1, 0, 0, 2'd0, 8'h00, 0));
    idle(2);

    // presets in PAUSE: legal seconds, then illegal tens
    cycle(1'b0, mk(0, 0, 1, 2'd1, 8'h45, 0));
    idle(1);
    cycle(1'b0, mk(0, 0, 1, 2'd1, 8'h60, 0));
    cycle(1'b0, mk(0, 0, 1, 2'd3, 8'h11, 0));
    idle(2);

    // lap freeze at 00:12.34 while counting continues
    chain = 1234;
    cycle(1'b0, mk(1, 0, 0, 2'd0, 8'h00, 0));
    cycle(1'b0, mk(0, 1, 0, 2'd0, 8'h00, 1));
    for (int i = 0; i < 4; i++) cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 1));
    cycle(1'b0, mk(0, 0, 1, 2'd0, 8'h12, 0));
    cycle(1'b0, mk(0, 1, 0, 2'd0, 8'h00, 1));
    cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 1));
    idle(1);

    // terminal count: stop variant halts, wrap variant wraps
    chain = 359999;
    cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 1));
    idle(2);
    cycle(1'b0, mk(1, 0, 0, 2'd0, 8'h00, 0));
    cycle(1'b0, mk(0, 0, 1, 2'd0, 8'h12, 0));
    cycle(1'b0, mk(0, 1, 0, 2'd0, 8'h00, 0));
    idle(2);

    // simultaneous keys from RUN, then clear from PAUSE
    cycle(1'b0, mk(1, 0, 0, 2'd0, 8'h00, 0));
    for (int i = 0; i < 3; i++) cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 1));
    cycle(1'b0, mk(1, 1, 0, 2'd0, 8'h00, 1));
    idle(1);
    cycle(1'b0, mk(0, 1, 1, 2'd2, 8'h33, 0));
    idle(2);

    // async reset while in LAP, then restart
    cycle(1'b0, mk(1, 0, 0, 2'd0, 8'h00, 0));
    cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 1));
    cycle(1'b0, mk(0, 1, 0, 2'd0, 8'h00, 1));
    cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 1));
    cycle(1'b1, mk(0, 0, 0, 2'd0, 8'h00, 1));
    idle(1);
    cycle(1'b0, mk(1, 0, 0, 2'd0, 8'h00, 0));
    cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 1));
    cycle(1'b0, mk(0, 0, 0, 2'd0, 8'h00, 1));

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) chain = int'($urandom_range(359990, 359999));
      s.ss   = ($urandom_range(0, 15) == 0);
      s.lr   = ($urandom_range(0, 15) == 0);
      s.ld   = ($urandom_range(0, 9) == 0);
      s.sel  = 2'($urandom_range(0, 3));
      s.val  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                           : {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      s.tick = ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 499) == 0, s);
    end

    @(negedge clk);
    #1;
    chk("queue_drained", 24'(exp_a.size() + exp_b.size()), 24'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
